// File: rtl/piso_serializer.sv
// Parallel-in serial-out shifter with a valid/ready load handshake and a shift enable.
// Words stream back-to-back: a new word may load on the same edge that retires the last bit.
module piso_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             en,
  output logic             sout,
  output logic             sout_valid,
  output logic             last
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int unsigned HEAD  = MSB_FIRST ? WIDTH - 1 : 0;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   sreg;
  logic [WIDTH-1:0]   sreg_shifted;
  logic [CNT_W-1:0]   bit_cnt;
  logic               load_fire;

  assign load_ready = (state == IDLE) || (last && en);
  assign load_fire  = load_valid && load_ready;

  // The head bit of the shift register is the serial output; the register is
  // zeroed whenever no word is active, so sout reads 0 outside valid cycles.
  assign sout = sreg[HEAD];

  always_comb begin
    sreg_shifted = '0;
    if (MSB_FIRST) begin
      sreg_shifted = {sreg[WIDTH-2:0], 1'b0};
    end else begin
      sreg_shifted = {1'b0, sreg[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sreg       <= '0;
      bit_cnt    <= '0;
      sout_valid <= 1'b0;
      last       <= 1'b0;
    end else if (load_fire) begin
      state      <= SHIFT;
      sreg       <= din;
      bit_cnt    <= '0;
      sout_valid <= 1'b1;
      last       <= 1'b0;
    end else if (state == SHIFT && en) begin
      if (last) begin
        state      <= IDLE;
        sreg       <= '0;
        bit_cnt    <= '0;
        sout_valid <= 1'b0;
        last       <= 1'b0;
      end else begin
        sreg    <= sreg_shifted;
        bit_cnt <= bit_cnt + 1'b1;
        last    <= (bit_cnt == CNT_W'(WIDTH - 2));
      end
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances share stimulus and are
// checked against a per-instance queue of pending serial bits.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       load_valid;
  logic       en;

  logic m_ready, m_sout, m_valid, m_last;
  logic l_ready, l_sout, l_valid, l_last;

  int unsigned checks = 0;
  int unsigned passes = 0;
  int unsigned fails  = 0;
  int unsigned vcnt   = 0;
  int unsigned lcnt   = 0;

  bit q_m[$];
  bit q_l[$];

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .din(din), .load_valid(load_valid), .load_ready(m_ready),
    .en(en), .sout(m_sout), .sout_valid(m_valid), .last(m_last)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .din(din), .load_valid(load_valid), .load_ready(l_ready),
    .en(en), .sout(l_sout), .sout_valid(l_valid), .last(l_last)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_ready(input int unsigned qsize, input logic e);
    return (qsize == 0) || (qsize == 1 && e);
  endfunction

  // One clock: check ready before the edge, advance the model at the edge, check outputs after.
  task automatic cyc(input logic r, input logic lv, input logic e, input logic [7:0] d);
    bit acc;
    rst = r; load_valid = lv; en = e; din = d;
    #1;
    chk("msb_ready", m_ready, model_ready(q_m.size(), e));
    chk("lsb_ready", l_ready, model_ready(q_l.size(), e));
    @(posedge clk);
    if (r) begin
      q_m.delete();
      q_l.delete();
    end else begin
      acc = lv && model_ready(q_m.size(), e);
      if (e && q_m.size() > 0) void'(q_m.pop_front());
      if (e && q_l.size() > 0) void'(q_l.pop_front());
      if (acc) begin
        for (int i = 7; i >= 0; i--) q_m.push_back(d[i]);
        for (int i = 0; i < 8; i++)  q_l.push_back(d[i]);
      end
    end
    #1;
    chk("msb_valid", m_valid, q_m.size() > 0);
    chk("msb_sout",  m_sout,  q_m.size() > 0 ? q_m[0] : 1'b0);
    chk("msb_last",  m_last,  q_m.size() == 1);
    chk("lsb_valid", l_valid, q_l.size() > 0);
    chk("lsb_sout",  l_sout,  q_l.size() > 0 ? q_l[0] : 1'b0);
    chk("lsb_last",  l_last,  q_l.size() == 1);
    if (m_valid) vcnt++;
    if (m_last)  lcnt++;
    @(negedge clk);
  endtask

  initial begin
    logic [1:0] ep;
    rst = 1'b1; load_valid = 1'b0; en = 1'b0; din = '0;
    @(negedge clk);

    // Reset with a pending load offered; ready must read 1 right after release.
    cyc(1'b1, 1'b1, 1'b1, 8'hFF);
    cyc(1'b1, 1'b1, 1'b1, 8'hFF);
    chk("ready_after_rst", m_ready, 1'b1);

    // Single word 8'hA5 (MSB) / 8'hA5 LSB order from the second instance.
    cyc(1'b0, 1'b1, 1'b1, 8'hA5);
    for (int i = 0; i < 9; i++) cyc(1'b0, 1'b0, 1'b1, 8'h00);

    // 8'h81 exercises LSB-first ordering with the same latency.
    cyc(1'b0, 1'b1, 1'b1, 8'h81);
    for (int i = 0; i < 9; i++) cyc(1'b0, 1'b0, 1'b1, 8'h00);

    // Stall: en low for 3 cycles while bit 2 is shown; 11 valid cycles in total.
    vcnt = 0;
    cyc(1'b0, 1'b1, 1'b1, 8'hC3);
    for (int i = 0; i < 11; i++) cyc(1'b0, 1'b0, !(i >= 2 && i <= 4), 8'h00);
    chk("stall_valid_cycles", vcnt, 11);

    // Back-to-back: 0x0F then 0xF0 with load_valid held; 16 contiguous valid cycles.
    vcnt = 0; lcnt = 0;
    cyc(1'b0, 1'b1, 1'b1, 8'h0F);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'b1, 8'hF0);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'b1, 8'h00);
    chk("b2b_valid_cycles", vcnt, 16);
    chk("b2b_last_pulses", lcnt, 2);

    // Mid-word reset after 3 bits, then a fresh word 8'h01.
    cyc(1'b0, 1'b1, 1'b1, 8'hFF);
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 1'b1, 8'h00);
    cyc(1'b1, 1'b1, 1'b1, 8'hFF);
    cyc(1'b0, 1'b1, 1'b1, 8'h01);
    for (int i = 0; i < 9; i++) cyc(1'b0, 1'b0, 1'b1, 8'h00);

    // Randomized traffic with stalls and occasional resets.
    for (int i = 0; i < 400; i++) begin
      ep = 2'($urandom_range(0, 3));
      cyc(($urandom_range(0, 49) == 0), 1'($urandom), (ep != 2'd0), 8'($urandom));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8; parallel word width, legal range 2..32.
REQ-002 SHALL have parameter MSB_FIRST, default 1; 1 = bit WIDTH-1 is shifted out first, 0 = bit 0 first.
REQ-003 SHALL have port clk, input, 1 bit; the single clock, all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit; synchronous, active-high reset.
REQ-005 SHALL have port din, input, WIDTH bits; parallel word to serialize.
REQ-006 SHALL have port load_valid, input, 1 bit; din is valid and offered for loading.
REQ-007 SHALL have port load_ready, output, 1 bit; block can accept din this cycle.
REQ-008 SHALL have port en, input, 1 bit; shift enable; low = hold all shift state.
REQ-009 SHALL have port sout, output, 1 bit; current serial bit.
REQ-010 SHALL have port sout_valid, output, 1 bit; sout carries a data bit.
REQ-011 SHALL have port last, output, 1 bit; sout is the final bit of the current word.

Function
REQ-012 SHALL implement a two-state FSM: IDLE and SHIFT.
REQ-013 SHALL complete a load on any rising edge where load_valid=1, load_ready=1 and rst=0; din is captured into an internal WIDTH-bit shift register and bit_cnt is cleared to 0.
REQ-014 SHALL drive load_ready combinationally: 1 in IDLE; 1 in SHIFT only when last=1 and en=1; 0 otherwise.
REQ-015 SHALL enter SHIFT on the edge completing a load from IDLE, with sout_valid=1 and sout equal to the first bit (din[WIDTH-1] if MSB_FIRST, else din[0]) in the following cycle; load-to-first-bit latency is 1 cycle.
REQ-016 SHALL, in SHIFT with en=1 at a rising edge, advance the shift register by one position and increment bit_cnt (0..WIDTH-1).
REQ-017 SHALL, in SHIFT with en=0, hold the shift register, bit_cnt, sout, sout_valid and last unchanged; en has no effect in IDLE.
REQ-018 SHALL assert last exactly when state is SHIFT and bit_cnt = WIDTH-1.
REQ-019 SHALL, when last=1 and en=1 at an edge with no load, return to IDLE with sout_valid=0, last=0 and sout=0 in the next cycle.
REQ-020 SHALL, when last=1, en=1 and load_valid=1 at the same edge, load the new word, remain in SHIFT, and present its first bit in the next cycle; back-to-back words SHALL stream with zero idle cycles.
REQ-021 SHALL ignore load_valid while in SHIFT with last=0 or en=0; din is not sampled then, and the upstream must hold it.
REQ-022 SHALL present exactly WIDTH sout_valid cycles with en=1 per accepted word, with no bit dropped or duplicated across stalls.
REQ-023 SHALL drive sout=0 whenever sout_valid=0.

Reset
REQ-024 SHALL, on any rising edge with rst=1, force state IDLE, shift register 0, bit_cnt 0, sout=0, sout_valid=0, last=0, regardless of en, load_valid or current state.
REQ-025 SHALL abort an in-progress word on a mid-word reset; the remaining bits are discarded and not emitted after rst falls.
REQ-026 SHALL not accept a load at an edge where rst=1; load_ready SHALL read 1 in the first cycle after rst deasserts.

Verification (WIDTH=8)
REQ-027 Reset: rst=1 for 2 cycles with load_valid=1 and din=8'hFF -> sout=0, sout_valid=0, last=0 throughout; load_ready=1 on the first cycle after release.
REQ-028 Single word, MSB_FIRST=1: load 8'hA5 with en=1 held -> sout=1,0,1,0,0,1,0,1 over 8 consecutive valid cycles; last only on the 8th; then sout_valid=0.
REQ-029 LSB_first (MSB_FIRST=0): load 8'h81 -> sout=1,0,0,0,0,0,0,1; same 1-cycle latency.
REQ-030 Stall: load 8'hC3; drop en for 3 cycles after bit 2 -> bit 2 value held for 4 cycles in total; total sout_valid cycles = 11; bit sequence is still 1,1,0,0,0,0,1,1.
REQ-031 Back-to-back: load_valid held with 8'h0F then 8'hF0 -> 16 contiguous valid cycles 0000111111110000; second load accepted on the cycle where last=1; last pulses twice.
REQ-032 Mid-word reset: load 8'hFF, assert rst after 3 bits -> next cycle IDLE with sout_valid=0; a fresh load of 8'h01 then emits 0,0,0,0,0,0,0,1.
